alu_sequencer: RTL

Multi-cycle controller that executes one 8085 arithmetic/logic instruction at a time on the shared combinational ALU. Accepts an opcode over a valid/ready handshake, reads operands from the 8-entry register file, drives the ALU, writes back the result, and owns the architectural flag register. Sits between the instruction decoder and the ALU/register file.

---
 rtl/alu_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 8085 arithmetic/logic instruction controller.
// Define ALU_IMM_EN to also accept the immediate forms ADI..CPI (11ooo110).
module alu_sequencer #(
  parameter logic [2:0] ACC_ADDR    = 3'd7,
  parameter logic [7:0] RESET_FLAGS = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr_op,
  input  logic [7:0] instr_imm,
  output logic       done,
  output logic       err,
  output logic [2:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic       alu_enable,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_f,
  input  logic [7:0] alu_r,
  input  logic [7:0] alu_fo,
  input  logic       alu_flag_wrbar,
  output logic [7:0] flags,
  input  logic       flags_load,
  input  logic [7:0] flags_din
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, ERR} state_t;
  state_t     r_state, w_next;
  logic       w_grp, w_inc, w_imm, w_accept, w_exec, w_wb, w_to_acc;
  logic [2:0] w_ooo;
  logic [3:0] w_aluop;
  logic       r_grp, r_imm_op, r_cmp, r_wrbar;
  logic [3:0] r_aluop;
  logic [2:0] r_ddd, r_sss;
  logic [7:0] r_imm, r_a, r_res, r_fo, r_flags;
  assign w_ooo   = instr_op[5:3];
  assign w_grp   = instr_op[7:6] == 2'b10 && instr_op[2:0] != 3'b110;
  assign w_inc   = instr_op[7:6] == 2'b00 && instr_op[2:1] == 2'b10 && w_ooo != 3'b110;
`ifdef ALU_IMM_EN
  assign w_imm   = instr_op[7:6] == 2'b11 && instr_op[2:0] == 3'b110;
`else
  assign w_imm   = 1'b0;
`endif
  assign w_aluop = w_inc ? {3'b100, instr_op[0]}
                         : {1'b0, w_ooo == 3'd5 ? 3'd6 : w_ooo == 3'd6 ? 3'd5 : w_ooo};
  assign w_accept = r_state == IDLE && instr_valid;
  assign w_exec   = r_state == EXEC;
  assign w_wb     = r_state == WB;
  assign w_to_acc = r_grp | r_imm_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !instr_valid ? IDLE : (w_grp | w_inc | w_imm) ? RD_A : ERR;
      RD_A:    w_next = r_grp ? RD_B : EXEC;
      RD_B:    w_next = EXEC;
      EXEC:    w_next = WB;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp    <= 1'b0;
      r_imm_op <= 1'b0;
      r_cmp    <= 1'b0;
      r_wrbar  <= 1'b1;
      r_aluop  <= 4'd0;
      r_ddd    <= 3'd0;
      r_sss    <= 3'd0;
      r_imm    <= 8'h00;
      r_a      <= 8'h00;
      r_res    <= 8'h00;
      r_fo     <= 8'h00;
      r_flags  <= RESET_FLAGS;
    end else begin
      if (w_accept) begin
        r_grp    <= w_grp;
        r_imm_op <= w_imm;
        r_cmp    <= (w_grp | w_imm) && w_ooo == 3'b111;
        r_aluop  <= w_aluop;
        r_ddd    <= w_ooo;
        r_sss    <= instr_op[2:0];
        r_imm    <= instr_imm;
      end
      if (r_state == RD_B) r_a <= rf_rdata;
      if (w_exec) begin
        r_res   <= alu_r;
        r_fo    <= alu_fo;
        r_wrbar <= alu_flag_wrbar;
      end
      // an ALU flag update in WB takes priority over an external load
      if (w_wb && !r_wrbar) r_flags <= r_fo;
      else if (flags_load)  r_flags <= flags_din;
    end
  end
  assign instr_ready = r_state == IDLE;
  assign done        = w_wb;
  assign err         = r_state == ERR;
  assign rf_raddr    = r_state == RD_A ? (w_to_acc ? ACC_ADDR : r_ddd)
                     : r_state == RD_B ? r_sss : 3'd0;
  assign rf_we       = w_wb && !r_cmp;
  assign rf_waddr    = w_wb ? (w_to_acc ? ACC_ADDR : r_ddd) : 3'd0;
  assign rf_wdata    = w_wb ? r_res : 8'h00;
  // the last operand read arrives on rf_rdata during EXEC and feeds the ALU directly
  assign alu_enable  = w_exec;
  assign alu_op      = w_exec ? r_aluop : 4'd0;
  assign alu_a       = w_exec ? (r_grp ? r_a : rf_rdata) : 8'h00;
  assign alu_b       = w_exec ? (r_grp ? rf_rdata : r_imm_op ? r_imm : 8'h00) : 8'h00;
  assign alu_f       = w_exec ? r_flags : 8'h00;
  assign flags       = r_flags;
endmodule
